// File: rtl/div_iter_core.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle, with an enable/ready/complete
// handshake. Signed operands are reduced to magnitudes, divided, then sign-corrected.
module div_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             sign_en,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             ready,
    output logic             complete
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic             sign_q, sign_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;    // dividend magnitude, becomes the quotient magnitude
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] prem_q, prem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             zdiv_q, zdiv_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    assign quo_o = quo_q;
    assign rem_o = rem_q;

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        sign_d   = sign_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        prem_d   = prem_q;
        cnt_d    = cnt_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        zdiv_d   = zdiv_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        ready    = 1'b0;
        complete = 1'b0;

        shifted  = {prem_q, dvd_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};

        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (enable) begin
                    op1_d   = op1;
                    op2_d   = op2;
                    sign_d  = sign_en;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                dvd_d   = (sign_q && op1_q[WIDTH-1]) ? -op1_q : op1_q;
                dvs_d   = (sign_q && op2_q[WIDTH-1]) ? -op2_q : op2_q;
                negq_d  = sign_q & (op1_q[WIDTH-1] ^ op2_q[WIDTH-1]);
                negr_d  = sign_q & op1_q[WIDTH-1];
                prem_d  = '0;
                cnt_d   = CW'(WIDTH - 1);
                zdiv_d  = (op2_q == '0);
                state_d = (op2_q == '0) ? S_FIX : S_ITER;
            end
            S_ITER: begin
                // The partial remainder stays below the divisor, so a failed trial fits in WIDTH bits.
                if (!trial[WIDTH]) begin
                    prem_d = trial[WIDTH-1:0];
                    dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
                end else begin
                    prem_d = shifted[WIDTH-1:0];
                    dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (zdiv_q) begin
                    quo_d = '1;
                    rem_d = op1_q;
                end else begin
                    quo_d = negq_q ? -dvd_q : dvd_q;
                    rem_d = negr_q ? -prem_q : prem_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                complete = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op1_q   <= '0;
            op2_q   <= '0;
            sign_q  <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zdiv_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            sign_q  <= sign_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zdiv_q  <= zdiv_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_div_iter_core.sv
// Scoreboard bench for div_iter_core: requests push expected results from an arithmetic model;
// a monitor pops and compares whenever complete is seen, including its arrival cycle.
module tb_div_iter_core;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         enable = 1'b0;
    logic         sign_en = 1'b0;
    logic [W-1:0] op1 = '0;
    logic [W-1:0] op2 = '0;
    logic [W-1:0] quo_o;
    logic [W-1:0] rem_o;
    logic         ready;
    logic         complete;

    div_iter_core #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .sign_en  (sign_en),
        .op1      (op1),
        .op2      (op2),
        .quo_o    (quo_o),
        .rem_o    (rem_o),
        .ready    (ready),
        .complete (complete)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        int           due;
    } exp_t;

    exp_t         sbq[$];
    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [W-1:0] last_quo = '0;
    logic [W-1:0] last_rem = '0;
    logic         prev_complete = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: truncating division on 64-bit integers, zero divisor handled explicitly.
    function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint x, y;
        if (b == '0) begin
            q = '1;
            r = a;
        end else begin
            if (s) begin
                x = longint'($signed(a));
                y = longint'($signed(b));
            end else begin
                x = longint'({32'b0, a});
                y = longint'({32'b0, b});
            end
            q = W'(x / y);
            r = W'(x % y);
        end
    endfunction

    // Monitor: one complete per pending request, at its due cycle; outputs hold otherwise.
    always @(negedge clk) begin
        if (!rst) begin
            if (complete) begin
                check("complete_not_back_to_back", W'(prev_complete), '0);
                if (sbq.size() == 0) begin
                    check("unexpected_complete", W'(1), '0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("quo", quo_o, e.quo);
                    check("rem", rem_o, e.rem);
                    check("latency_cycle", W'(cyc), W'(e.due));
                    last_quo = e.quo;
                    last_rem = e.rem;
                end
            end else begin
                check("quo_hold", quo_o, last_quo);
                check("rem_hold", rem_o, last_rem);
                if (sbq.size() > 0 && cyc > sbq[0].due) begin
                    check("complete_timeout", W'(0), W'(1));
                    void'(sbq.pop_front());
                end
            end
            prev_complete = complete;
        end
    end

    // Waits for ready, presents a request, returns the cycle count of the accepting edge.
    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold, output int c);
        int   w;
        exp_t e;
        w = 0;
        @(negedge clk);
        while (!ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!ready) check("ready_timeout", W'(ready), W'(1));
        sign_en = s;
        op1     = a;
        op2     = b;
        enable  = 1'b1;
        @(posedge clk);
        #1;
        c = cyc;
        model(s, a, b, e.quo, e.rem);
        // Request at edge T: PREP is the period counted c, so DONE is c+34 (c+2 for zero divisor).
        e.due = c + ((b == '0) ? 2 : 34);
        sbq.push_back(e);
        @(negedge clk);
        if (!hold) enable = 1'b0;
        op1     = $urandom;
        op2     = $urandom;
        sign_en = 1'($urandom);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() > 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() > 0) check("drain_timeout", W'(sbq.size()), '0);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return W'($urandom_range(0, 20));
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'hFFFF_FFF0 | W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int c;
        logic [W-1:0] a, b;
        logic s;

        #2;
        check("reset_ready", W'(ready), W'(1));
        check("reset_complete", W'(complete), '0);
        check("reset_quo", quo_o, '0);
        check("reset_rem", rem_o, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 100/7 with ready profile: low through DONE, high again the cycle after.
        issue(1'b0, 32'd100, 32'd7, 1'b0, c);
        for (int k = 0; k < 36; k++) begin
            if (k > 0) @(negedge clk);
            check("ready_profile", W'(ready), W'(cyc >= c + 35));
        end
        drain();

        issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, c);
        issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, c);
        issue(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, c);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, c);
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, c);
        issue(1'b0, 32'd5, 32'd0, 1'b0, c);
        issue(1'b1, 32'd5, 32'd0, 1'b0, c);
        issue(1'b0, 32'd9, 32'd3, 1'b0, c);
        drain();

        // enable pulse while busy must be dropped, not queued.
        issue(1'b0, 32'd1000, 32'd33, 1'b0, c);
        repeat (8) @(negedge clk);
        check("busy_ready_low", W'(ready), '0);
        op1    = 32'd77;
        op2    = 32'd5;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Random traffic, enable often held high to exercise back-to-back acceptance.
        for (int i = 0; i < 30; i++) begin
            s = 1'($urandom);
            a = rand_op();
            b = rand_op();
            issue(s, a, b, 1'($urandom), c);
        end
        enable = 1'b0;
        drain();

        // Asynchronous reset mid-iteration abandons the division.
        issue(1'b0, 32'd12345, 32'd67, 1'b0, c);
        repeat (19) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ready", W'(ready), W'(1));
        check("midrst_quo", quo_o, '0);
        check("midrst_rem", rem_o, '0);
        sbq.delete();
        last_quo = '0;
        last_rem = '0;
        prev_complete = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);

        issue(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, c);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
